// File: rtl/state_tower_n_if.sv
// Handshake bundle for state_tower_n: an input beat channel and a registered result channel.
// The master side drives beats and consumes results; the slave side is the tower itself.
interface state_tower_n_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic [WIDTH-1:0] top_layer;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_count, top_layer
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_count, top_layer
    );
endinterface

// File: rtl/state_tower_n.sv
// Stack of LAYERS WIDTH-bit state registers updated per accepted beat (hold/load/xor/invert).
// Each accept produces a single-entry registered result: XOR of all updated layers plus a beat count.
module state_tower_n #(
    parameter int               LAYERS    = 4,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
    parameter int               CNT_W     = 8
) (
    input logic             clk,
    input logic             rst,
    state_tower_n_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_INV  = 2'b11
    } mode_e;

    typedef logic [LAYERS-1:0][WIDTH-1:0] stack_t;

    function automatic logic [WIDTH-1:0] xor_fold(input stack_t s);
        logic [WIDTH-1:0] acc;
        acc = {WIDTH{1'b0}};
        for (int k = 0; k < LAYERS; k++) begin
            acc = acc ^ s[k];
        end
        return acc;
    endfunction

    stack_t           layer_r;
    stack_t           next_layer_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [CNT_W-1:0] out_count_r;
    logic             in_ready_s;
    logic             accept_s;

    // A pending result blocks new beats unless the consumer takes it this same cycle.
    assign in_ready_s = !out_valid_r || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;

    // Next-state of every layer, all computed from pre-update values.
    always_comb begin
        next_layer_s = layer_r;
        case (mode_e'(bus.in_mode))
            MODE_HOLD: begin
                next_layer_s = layer_r;
            end
            MODE_LOAD: begin
                next_layer_s[0] = bus.in_data;
                for (int k = 1; k < LAYERS; k++) begin
                    next_layer_s[k] = layer_r[k-1];
                end
            end
            MODE_XOR: begin
                next_layer_s[0] = layer_r[0] ^ bus.in_data;
                for (int k = 1; k < LAYERS; k++) begin
                    next_layer_s[k] = layer_r[k] ^ layer_r[k-1];
                end
            end
            MODE_INV: begin
                for (int k = 0; k < LAYERS; k++) begin
                    next_layer_s[k] = layer_r[k] ^ bus.in_data;
                end
            end
            default: begin
                next_layer_s = layer_r;
            end
        endcase
    end

    // Layer stack and result register; output data/count only move on an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_r     <= {LAYERS{RESET_VAL}};
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_count_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            layer_r     <= next_layer_s;
            out_valid_r <= 1'b1;
            out_data_r  <= xor_fold(next_layer_s);
            out_count_r <= out_count_r + CNT_W'(1'b1);
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_count = out_count_r;
    assign bus.top_layer = layer_r[LAYERS-1];

endmodule

// File: tb/tb_state_tower_n.sv
// Self-checking bench for state_tower_n: directed scenarios plus randomized beats against
// a layer-array reference model; a second instance with a 2-bit counter covers wrap-around.
module tb_state_tower_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    state_tower_n_if #(.WIDTH(8), .CNT_W(8)) bus ();
    state_tower_n_if #(.WIDTH(8), .CNT_W(2)) wbus ();

    state_tower_n #(.LAYERS(4), .WIDTH(8), .RESET_VAL(8'hFF), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    state_tower_n #(.LAYERS(4), .WIDTH(8), .RESET_VAL(8'hFF), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .bus(wbus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_l [4];
    logic       m_valid;
    logic [7:0] m_data;
    logic [7:0] m_count;
    logic       exp_ready;
    logic       act_ready;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_l[k] = 8'hFF;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_count = 8'h00;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        wbus.in_valid  = 1'b0;
        wbus.in_mode   = 2'b00;
        wbus.in_data   = 8'h00;
        wbus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock on the main instance: drive, sample in_ready, clock, then advance the model.
    task automatic step(input logic v, input logic [1:0] mode, input logic [7:0] d, input logic ordy);
        logic [7:0] n [4];
        logic       acc;
        bus.in_valid  = v;
        bus.in_mode   = mode;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        exp_ready = !m_valid || ordy;
        act_ready = bus.in_ready;
        acc = v && exp_ready;
        @(posedge clk); #1;
        if (acc) begin
            for (int k = 0; k < 4; k++) n[k] = m_l[k];
            case (mode)
                2'd1: begin
                    n[0] = d;
                    for (int k = 1; k < 4; k++) n[k] = m_l[k-1];
                end
                2'd2: begin
                    n[0] = m_l[0] ^ d;
                    for (int k = 1; k < 4; k++) n[k] = m_l[k] ^ m_l[k-1];
                end
                2'd3: for (int k = 0; k < 4; k++) n[k] = m_l[k] ^ d;
                default: ;
            endcase
            m_data = 8'h00;
            for (int k = 0; k < 4; k++) begin
                m_l[k] = n[k];
                m_data = m_data ^ n[k];
            end
            m_count = m_count + 8'd1;
            m_valid = 1'b1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.out_data); end
        checks++;
        if (bus.out_count !== 8'h00) begin failures++; $display("FAIL reset_count got=%h exp=00", bus.out_count); end
        checks++;
        rst = 1'b0;
        model_reset();
        #1;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.in_ready); end
        checks++;
        if (bus.top_layer !== 8'hFF) begin failures++; $display("FAIL reset_top got=%h exp=FF", bus.top_layer); end
        checks++;
    endtask

    task automatic test_hold();
        do_reset();
        step(1'b1, 2'b00, 8'h5A, 1'b1);
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%0b exp=1", bus.out_valid); end
        checks++;
        if (bus.out_data !== 8'h00) begin failures++; $display("FAIL hold_data got=%h exp=00", bus.out_data); end
        checks++;
        if (bus.out_count !== 8'd1) begin failures++; $display("FAIL hold_count got=%0d exp=1", bus.out_count); end
        checks++;
        if (bus.top_layer !== 8'hFF) begin failures++; $display("FAIL hold_top got=%h exp=FF", bus.top_layer); end
        checks++;
    endtask

    task automatic test_back_to_back_load();
        logic [7:0] exp_d [2];
        exp_d[0] = 8'hED;
        exp_d[1] = 8'h26;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 2'b01, (i == 0) ? 8'h12 : 8'h34, 1'b1);
            if (act_ready !== 1'b1) begin failures++; $display("FAIL load_ready[%0d] got=%0b exp=1", i, act_ready); end
            checks++;
            if (bus.out_data !== exp_d[i]) begin failures++; $display("FAIL load_data[%0d] got=%h exp=%h", i, bus.out_data, exp_d[i]); end
            checks++;
            if (bus.out_count !== 8'(i + 1)) begin failures++; $display("FAIL load_count[%0d] got=%0d exp=%0d", i, bus.out_count, i + 1); end
            checks++;
            if (bus.top_layer !== 8'hFF) begin failures++; $display("FAIL load_top[%0d] got=%h exp=FF", i, bus.top_layer); end
            checks++;
        end
    endtask

    task automatic test_xor_inv();
        do_reset();
        step(1'b1, 2'b10, 8'h01, 1'b1);
        if (bus.out_data !== 8'hFE) begin failures++; $display("FAIL xor_data got=%h exp=FE", bus.out_data); end
        checks++;
        if (bus.top_layer !== 8'h00) begin failures++; $display("FAIL xor_top got=%h exp=00", bus.top_layer); end
        checks++;
        do_reset();
        step(1'b1, 2'b11, 8'h0F, 1'b1);
        if (bus.out_data !== 8'h00) begin failures++; $display("FAIL inv_data got=%h exp=00", bus.out_data); end
        checks++;
        if (bus.top_layer !== 8'hF0) begin failures++; $display("FAIL inv_top got=%h exp=F0", bus.top_layer); end
        checks++;
    endtask

    task automatic test_backpressure();
        logic [7:0] held_cnt;
        logic [7:0] held_data;
        do_reset();
        step(1'b1, 2'b01, 8'hA5, 1'b0);
        held_cnt  = m_count;
        held_data = m_data;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b01, 8'(8'h30 + i), 1'b0);
            if (act_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%0b exp=0", i, act_ready); end
            checks++;
            if (bus.out_count !== held_cnt || bus.out_data !== held_data) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%h/%h exp=%h/%h", i, bus.out_count, bus.out_data, held_cnt, held_data);
            end
            checks++;
            if (bus.top_layer !== 8'hFF) begin failures++; $display("FAIL bp_top[%0d] got=%h exp=FF", i, bus.top_layer); end
            checks++;
        end
        step(1'b1, 2'b01, 8'h77, 1'b1);
        if (act_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", act_ready); end
        checks++;
        if (bus.out_count !== 8'(held_cnt + 8'd1)) begin failures++; $display("FAIL bp_release_count got=%0d exp=%0d", bus.out_count, held_cnt + 8'd1); end
        checks++;
        if (bus.out_data !== m_data || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_release_data got=%h exp=%h", bus.out_data, m_data); end
        checks++;
    endtask

    task automatic test_random();
        logic       v;
        logic       ordy;
        logic [1:0] mode;
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v    = ($urandom_range(3, 0) != 0);
            ordy = ($urandom_range(2, 0) != 0);
            mode = 2'($urandom_range(3, 0));
            d    = 8'($urandom_range(255, 0));
            step(v, mode, d, ordy);
            if (act_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready[%0d] got=%0b exp=%0b", i, act_ready, exp_ready); end
            checks++;
            if (bus.out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", i, bus.out_valid, m_valid); end
            checks++;
            if (bus.out_data !== m_data) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, bus.out_data, m_data); end
            checks++;
            if (bus.out_count !== m_count) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, bus.out_count, m_count); end
            checks++;
            if (bus.top_layer !== m_l[3]) begin failures++; $display("FAIL rnd_top[%0d] got=%h exp=%h", i, bus.top_layer, m_l[3]); end
            checks++;
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_c;
        do_reset();
        wbus.in_valid  = 1'b1;
        wbus.in_mode   = 2'b00;
        wbus.in_data   = 8'h3C;
        wbus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            exp_c = 2'((i + 1) % 4);
            if (wbus.out_count !== exp_c) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", i, wbus.out_count, exp_c); end
            checks++;
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 2'b01, 8'h11, 1'b0);
        step(1'b1, 2'b10, 8'h22, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_count !== 8'h00) begin
            failures++;
            $display("FAIL areset_out got=%0b/%h/%h exp=0/00/00", bus.out_valid, bus.out_data, bus.out_count);
        end
        checks++;
        if (bus.top_layer !== 8'hFF) begin failures++; $display("FAIL areset_top got=%h exp=FF", bus.top_layer); end
        checks++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        if (bus.out_valid !== 1'b0 || bus.out_count !== 8'h00) begin
            failures++;
            $display("FAIL areset_drop got=%0b/%0d exp=0/0", bus.out_valid, bus.out_count);
        end
        checks++;
        step(1'b1, 2'b00, 8'h5A, 1'b1);
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00 || bus.out_count !== 8'd1 || bus.top_layer !== 8'hFF) begin
            failures++;
            $display("FAIL areset_first got=%0b/%h/%0d/%h exp=1/00/1/FF", bus.out_valid, bus.out_data, bus.out_count, bus.top_layer);
        end
        checks++;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        test_reset();
        test_hold();
        test_back_to_back_load();
        test_xor_inv();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/state_tower_n.md
# state_tower_n

Parametrised stack of LAYERS state registers, each WIDTH bits wide, updated together on each accepted input beat. Each beat applies one of four modes: hold, push/load, xor-cascade or invert. The result is a single-entry registered output: the XOR reduction of all layers after the update, plus a beat counter. It is the general-width, N-layer successor of the fixed 2-bit, 1-bit-I/O state-machine blocks in the design. Valid/ready handshakes on both sides allow stalls from the consumer.

## Interface
- LAYERS, 4, number of stacked state layers (>= 2)
- WIDTH, 8, bits per layer and per data word (>= 1)
- RESET_VAL, all ones ({WIDTH{1'b1}}), reset value loaded into every layer
- CNT_W, 8, width of beat counter
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input beat offered
- in_ready  out  1  block can accept beat this cycle
- in_mode  in  2  00 HOLD, 01 LOAD, 10 XOR, 11 INV
- in_data  in  WIDTH  beat operand
- out_valid  out  1  out_data/out_count hold an unconsumed result
- out_ready  in  1  consumer takes result this cycle
- out_data  out  WIDTH  XOR of all layers after the accepted beat's update
- out_count  out  CNT_W  number of beats accepted since reset, including this one, mod 2^CNT_W
- top_layer  out  WIDTH  live (unregistered view of register) value of layer LAYERS-1

## Operation
- Accept = in_valid & in_ready; in_ready = !out_valid | out_ready (combinational, no dependence on in_valid).
- On accept, all layers update simultaneously from their pre-update values (L[k] = layer k, L[0] nearest input):
  - HOLD: no layer change.
  - LOAD: L[0] <= in_data; L[k] <= L[k-1] for k >= 1; old L[LAYERS-1] discarded.
  - XOR: L[0] <= L[0] ^ in_data; L[k] <= L[k] ^ L[k-1] for k >= 1.
  - INV: L[k] <= L[k] ^ in_data for every k.
- Same edge: out_data <= XOR over k of the post-update L[k]; out_count <= out_count + 1 (wraps to 0); out_valid <= 1.
- No accept and out_ready=1: out_valid <= 0, out_data/out_count keep last value.
- No accept and out_ready=0: all output state holds.
- Accept and consume in the same cycle is legal: out_valid stays 1 with new data. This gives full throughput of one beat per clock.
- Reset (async, any time, including mid-stall): all L[k] = RESET_VAL, out_valid = 0, out_data = 0, out_count = 0. After reset deasserts, in_ready = 1 and top_layer = RESET_VAL. A beat presented during the reset cycle is dropped.

## Timing
- Latency: accepted beat → out_valid high on the following clock edge (1 cycle).
- out_data and out_count are stable while out_valid=1 and out_ready=0.
- top_layer reflects the register: it changes on the edge after accept, same edge as out_data.
- There are no combinational paths from in_data or in_mode to any output. The only combinational paths are out_ready → in_ready and out_valid → in_ready.
- All arithmetic is bitwise XOR on WIDTH bits. The counter is unsigned modular.

## Test plan
- Reset, then HOLD with in_data=0x5A (LAYERS=4, WIDTH=8) → next cycle out_valid=1, out_data=0x00, out_count=1, top_layer=0xFF.
- From reset: LOAD 0x12 then LOAD 0x34 back-to-back with out_ready=1 → out_data 0xED then 0x26, out_count 1 then 2, top_layer 0xFF throughout.
- From reset: XOR 0x01 → layers {FE,00,00,00}, out_data=0xFE, top_layer=0x00. From reset: INV 0x0F → all layers 0xF0, out_data=0x00.
- Backpressure: result pending with out_ready=0 and in_valid=1 for 5 cycles → in_ready=0, out_data/out_count unchanged, no layer change. Raise out_ready → the pending beat is accepted that cycle and out_count increments by exactly 1.
- Wrap: CNT_W=2, 5 accepted HOLD beats → out_count sequence 1,2,3,0,1.
- Assert rst mid-stream while out_valid=1 and out_ready=0 → out_valid=0, out_data=0, out_count=0 and top_layer=0xFF immediately (async). The first beat after release behaves as the first beat after power-up.
